// File: rtl/uarc_console_pkg.sv
// Shared types and constants for the UARC host-console bridge.
package uarc_console_pkg;

    localparam int unsigned BYTE_WIDTH = 8;

    typedef enum logic {
        S_IDLE,
        S_SEND
    } sender_state_e;

    typedef enum logic {
        A_IDLE,
        A_ACK
    } acceptor_state_e;

endpackage

// File: rtl/uarc_byte_fifo.sv
// First-word-fall-through byte FIFO with wrap-bit pointers; head is valid whenever !empty.
module uarc_byte_fifo
    import uarc_console_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  push,
    input  logic [BYTE_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [BYTE_WIDTH-1:0] head,
    output logic                  empty,
    output logic                  full
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic [BYTE_WIDTH-1:0] mem_q [DEPTH];
    logic [BYTE_WIDTH-1:0] mem_d [DEPTH];

    assign empty = (wr_ptr_q == rd_ptr_q);
    // Same slot, opposite lap: the writer is one full pass ahead.
    assign full  = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                   (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
    assign head  = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push && !full) begin
            mem_d[wr_ptr_q[ADDR_WIDTH-1:0]] = push_data;
            wr_ptr_d = wr_ptr_q + (ADDR_WIDTH+1)'(1);
        end
        if (pop && !empty) begin
            rd_ptr_d = rd_ptr_q + (ADDR_WIDTH+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/uarc_console_bridge.sv
// Host-console peer for core0: host bytes go to the core receiver bus, core global sends
// come back to the host as bytes.
module uarc_console_bridge
    import uarc_console_pkg::*;
#(
    parameter  int unsigned WORD_MAG        = 5,
    localparam int unsigned WORD_WIDTH      = 1 << WORD_MAG,
    parameter  int unsigned FIFO_ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BYTE_WIDTH-1:0] in_byte,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BYTE_WIDTH-1:0] out_byte,
    output logic                  core_send,
    output logic [WORD_WIDTH-1:0] core_data,
    input  logic                  core_send_ack,
    input  logic                  core_sender_enable,
    input  logic                  core_global_send,
    input  logic [WORD_WIDTH-1:0] core_global_data,
    output logic                  core_sender_send_ack
);

    logic                  in_full, in_empty, in_pop, in_push;
    logic [BYTE_WIDTH-1:0] in_head;
    logic                  out_full, out_empty, out_push, out_pop;
    logic                  capture;
    logic                  unused_upper;

    sender_state_e         s_state_q, s_state_d;
    acceptor_state_e       a_state_q, a_state_d;
    logic                  core_send_q, core_send_d;
    logic [WORD_WIDTH-1:0] core_data_q, core_data_d;
    logic                  ack_q, ack_d;

    assign in_ready  = !in_full;
    assign in_push   = in_valid && !in_full;
    assign out_valid = !out_empty;
    assign out_pop   = !out_empty && out_ready;

    assign core_send            = core_send_q;
    assign core_data            = core_data_q;
    assign core_sender_send_ack = ack_q;
    assign unused_upper         = ^core_global_data[WORD_WIDTH-1:BYTE_WIDTH];

    uarc_byte_fifo #(
        .ADDR_WIDTH (FIFO_ADDR_WIDTH)
    ) u_in_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (in_push),
        .push_data (in_byte),
        .pop       (in_pop),
        .head      (in_head),
        .empty     (in_empty),
        .full      (in_full)
    );

    uarc_byte_fifo #(
        .ADDR_WIDTH (FIFO_ADDR_WIDTH)
    ) u_out_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (out_push),
        .push_data (core_global_data[BYTE_WIDTH-1:0]),
        .pop       (out_pop),
        .head      (out_byte),
        .empty     (out_empty),
        .full      (out_full)
    );

    // Sender: each ack either reloads the next byte back-to-back or drops core_send.
    always_comb begin
        s_state_d   = s_state_q;
        core_send_d = core_send_q;
        core_data_d = core_data_q;
        in_pop      = 1'b0;
        unique case (s_state_q)
            S_IDLE: begin
                if (!in_empty) begin
                    in_pop      = 1'b1;
                    core_send_d = 1'b1;
                    core_data_d = WORD_WIDTH'(in_head);
                    s_state_d   = S_SEND;
                end
            end
            S_SEND: begin
                if (core_send_ack) begin
                    if (!in_empty) begin
                        in_pop      = 1'b1;
                        core_data_d = WORD_WIDTH'(in_head);
                    end else begin
                        core_send_d = 1'b0;
                        s_state_d   = S_IDLE;
                    end
                end
            end
            default: s_state_d = S_IDLE;
        endcase
    end

    // Acceptor: A_ACK blanks capture for the cycle where global_send is still high.
    assign capture  = (a_state_q == A_IDLE) && core_sender_enable && core_global_send &&
                      !out_full;
    assign out_push = capture;

    always_comb begin
        a_state_d = a_state_q;
        ack_d     = capture;
        unique case (a_state_q)
            A_IDLE:  if (capture) a_state_d = A_ACK;
            A_ACK:   a_state_d = A_IDLE;
            default: a_state_d = A_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_state_q   <= S_IDLE;
            core_send_q <= 1'b0;
            core_data_q <= '0;
            a_state_q   <= A_IDLE;
            ack_q       <= 1'b0;
        end else begin
            s_state_q   <= s_state_d;
            core_send_q <= core_send_d;
            core_data_q <= core_data_d;
            a_state_q   <= a_state_d;
            ack_q       <= ack_d;
        end
    end

endmodule

// File: tb/tb_uarc_console_bridge.sv
// Directed self-checking bench for uarc_console_bridge.
module tb_uarc_console_bridge;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_byte;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_byte;
    logic        core_send;
    logic [31:0] core_data;
    logic        core_send_ack;
    logic        core_sender_enable;
    logic        core_global_send;
    logic [31:0] core_global_data;
    logic        core_sender_send_ack;

    int checks = 0;
    int errors = 0;
    int ack_cnt = 0;

    always #5 clk = ~clk;

    always @(negedge clk) if (core_sender_send_ack) ack_cnt++;

    uarc_console_bridge dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .in_valid             (in_valid),
        .in_ready             (in_ready),
        .in_byte              (in_byte),
        .out_valid            (out_valid),
        .out_ready            (out_ready),
        .out_byte             (out_byte),
        .core_send            (core_send),
        .core_data            (core_data),
        .core_send_ack        (core_send_ack),
        .core_sender_enable   (core_sender_enable),
        .core_global_send     (core_global_send),
        .core_global_data     (core_global_data),
        .core_sender_send_ack (core_sender_send_ack)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset_n            = 1'b0;
        in_valid           = 1'b0;
        in_byte            = '0;
        out_ready          = 1'b0;
        core_send_ack      = 1'b0;
        core_sender_enable = 1'b0;
        core_global_send   = 1'b0;
        core_global_data   = '0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Core model: hold send until ack is seen, then drop it one edge later.
    task automatic core_tx(input logic [31:0] w, input string tag);
        logic ok;
        ok                 = 1'b0;
        core_sender_enable = 1'b1;
        core_global_send   = 1'b1;
        core_global_data   = w;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (core_sender_send_ack) ok = 1'b1;
        end
        @(posedge clk);
        #1 core_global_send = 1'b0;
        check(tag, 32'(ok), 32'd1);
    endtask

    logic [31:0] got_q [10];
    int          n_got;
    int          idx;
    int          ack0;
    logic        acc;
    logic        exp_send [6];
    logic [31:0] exp_data [6];

    initial begin
        // Reset, then reset again with a byte in flight.
        do_reset();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_core_send", 32'(core_send), 32'd0);
        in_valid = 1'b1;
        in_byte  = 8'h41;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_pre_send", 32'(core_send), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_send", 32'(core_send), 32'd0);
        check("midrst_data", core_data, 32'h0);
        check("midrst_sack", 32'(core_sender_send_ack), 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("postrst_in_ready", 32'(in_ready), 32'd1);
        check("postrst_out_valid", 32'(out_valid), 32'd0);
        check("postrst_discard", 32'(core_send), 32'd0);

        // Single byte: two-cycle latency, held without ack, dropped after one ack.
        in_valid = 1'b1;
        in_byte  = 8'h41;
        @(negedge clk);
        check("single_c0_send", 32'(core_send), 32'd0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("single_c1_send", 32'(core_send), 32'd0);
        @(negedge clk);
        check("single_c2_send", 32'(core_send), 32'd1);
        check("single_c2_data", core_data, 32'h0000_0041);
        for (int c = 3; c < 7; c++) begin
            @(negedge clk);
            check("single_hold_send", 32'(core_send), 32'd1);
            check("single_hold_data", core_data, 32'h0000_0041);
        end
        @(posedge clk);
        #1 core_send_ack = 1'b1;
        @(negedge clk);
        check("single_c7_send", 32'(core_send), 32'd1);
        @(posedge clk);
        #1 core_send_ack = 1'b0;
        @(negedge clk);
        check("single_c8_send", 32'(core_send), 32'd0);
        check("single_c8_data", core_data, 32'h0000_0041);

        // Burst with ack tied high.
        exp_send = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        exp_data = '{32'h0, 32'h0, 32'h10, 32'h11, 32'h12, 32'h0};
        @(posedge clk);
        #1 core_send_ack = 1'b1;
        for (int c = 0; c < 6; c++) begin
            in_valid = (c < 3);
            in_byte  = 8'(8'h10 + c);
            @(negedge clk);
            check("burst_send", 32'(core_send), 32'(exp_send[c]));
            if (exp_send[c]) check("burst_data", core_data, exp_data[c]);
            @(posedge clk);
            #1;
        end
        in_valid      = 1'b0;
        core_send_ack = 1'b0;

        // Core output: one ack pulse, low byte lands in the output FIFO.
        ack0 = ack_cnt;
        core_tx(32'hDEAD_BE48, "coreout_ack_seen");
        repeat (4) @(posedge clk);
        #1;
        check("coreout_ack_pulses", 32'(ack_cnt - ack0), 32'd1);
        check("coreout_valid", 32'(out_valid), 32'd1);
        check("coreout_byte", 32'(out_byte), 32'h48);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("coreout_drained", 32'(out_valid), 32'd0);

        // Backpressure: ninth transfer stalls until one pop.
        for (int i = 1; i <= 8; i++) begin
            core_tx(32'hABCD_0000 | 32'(i), "bp_fill_ack");
        end
        core_global_send = 1'b1;
        core_global_data = 32'hABCD_0009;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_stall_ack", 32'(core_sender_send_ack), 32'd0);
        end
        check("bp_head", 32'(out_byte), 32'h01);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("bp_ack_wait", 32'(core_sender_send_ack), 32'd0);
        @(negedge clk);
        check("bp_ack_late", 32'(core_sender_send_ack), 32'd1);
        @(posedge clk);
        #1 core_global_send = 1'b0;
        for (int k = 2; k <= 9; k++) begin
            @(negedge clk);
            check("bp_drain_valid", 32'(out_valid), 32'd1);
            check("bp_drain_byte", 32'(out_byte), 32'(k));
            out_ready = 1'b1;
            @(posedge clk);
            #1 out_ready = 1'b0;
        end
        check("bp_empty", 32'(out_valid), 32'd0);
        core_sender_enable = 1'b0;

        // Full input path: 8 in FIFO + 1 in core_data, then drain in order.
        do_reset();
        idx      = 0;
        in_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            in_byte = 8'(8'h60 + idx);
            @(negedge clk);
            if (in_ready) idx++;
            @(posedge clk);
            #1;
        end
        check("full_accepted", 32'(idx), 32'd9);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_core_data", core_data, 32'h60);
        core_send_ack = 1'b1;
        n_got = 0;
        for (int c = 0; c < 30 && n_got < 10; c++) begin
            @(negedge clk);
            if (core_send) begin
                got_q[n_got] = core_data;
                n_got++;
            end
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) in_valid = 1'b0;
        end
        check("full_count", 32'(n_got), 32'd10);
        for (int k = 0; k < 10; k++) begin
            check("full_order", got_q[k], 32'h60 + 32'(k));
        end
        check("full_send_low", 32'(core_send), 32'd0);
        core_send_ack = 1'b0;
        in_valid      = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
